pll_lock_sequencer: RTL and testbench
=====================================

# pll_lock_sequencer

Brings the core up cleanly from the system PLL. It pulses the PLL reset, waits for `locked` with a timeout and retry, requires lock to stay stable for a settle window, and only then releases the core reset. On loss of lock in run mode it re-sequences. It sits between the PLL wrapper and the core's reset tree, and is clocked from the free-running 50 MHz reference, never from a PLL output.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth for `pll_locked`; minimum 2.
- `PLL_RST_CYCLES`, 16: cycles `pll_rst` is held per attempt; minimum 1.
- `LOCK_TIMEOUT`, 1000000: cycles allowed in WAIT_LOCK before retrying; minimum 2.
- `SETTLE_CYCLES`, 1024: cycles `locked` must stay high before release; minimum 1.
- `clk_sys` in 1: free-running 50 MHz reference clock.
- `reset` in 1: synchronous, active-high.
- `pll_locked` in 1: PLL lock, asynchronous to `clk_sys`.
- `pll_rst` out 1: reset request to the PLL.
- `core_reset` out 1: core reset; high in every state except RUN.
- `ready` out 1: high only in RUN.
- `lock_lost` out 1: one-cycle pulse when lock is lost in RUN.
- `loss_count` out 8: saturating lock-loss counter; present only with the macro.

## Operation
- `pll_locked` passes through a `SYNC_STAGES`-flop synchronizer, giving `locked_s`. The FSM uses only `locked_s`.
- One shared counter `cnt` is sized for the maximum of all three parameters. It is cleared on every state change.
- PLL_RST: `pll_rst`=1. When `cnt`==`PLL_RST_CYCLES`-1, go to WAIT_LOCK.
- WAIT_LOCK: `pll_rst`=0.
  - If `locked_s`=1, go to SETTLE.
  - Else if `cnt`==`LOCK_TIMEOUT`-1, go to PLL_RST (retry).
  - Retries are unlimited.
- SETTLE:
  - If `locked_s`=0, go to WAIT_LOCK (glitch; timeout restarts).
  - Else if `cnt`==`SETTLE_CYCLES`-1, go to RUN.
- RUN: `core_reset`=0, `ready`=1. If `locked_s`=0:
  - pulse `lock_lost` for one cycle;
  - increment `loss_count`, saturating at 255;
  - go to PLL_RST.
- Simultaneous events:
  - In WAIT_LOCK, lock detection has priority over timeout on the same cycle.
  - In SETTLE, lock loss has priority over settle completion.
- `reset` has priority over every transition.

## Timing
- All outputs are registered. They are decoded from the state register, with `lock_lost` registered on the RUN→PLL_RST transition.
- Reset values:
  - state = PLL_RST, `cnt` = 0;
  - `pll_rst` = 1, `core_reset` = 1, `ready` = 0, `lock_lost` = 0;
  - `loss_count` = 0;
  - synchronizer flops = 0.
- `pll_rst` stays high for exactly `PLL_RST_CYCLES` cycles after `reset` deasserts.
- Lock latency: if `pll_locked` rises at edge t, then:
  - `locked_s` rises at t+`SYNC_STAGES`;
  - SETTLE is entered at t+`SYNC_STAGES`+1;
  - `core_reset` falls at t+`SYNC_STAGES`+1+`SETTLE_CYCLES`.
- Loss latency: `pll_locked` falls at t while in RUN. Then `core_reset`=1, `lock_lost`=1 and `pll_rst`=1 all appear at t+`SYNC_STAGES`+1.
- `reset` asserted mid-sequence: state returns to PLL_RST on the next edge and `loss_count` clears.

## Configuration
- `PLL_LOSS_COUNT_EN` defined:
  - `loss_count` port and counter exist;
  - 8-bit, saturating at 255, cleared only by `reset`.
- Not defined:
  - port and counter are absent;
  - `lock_lost` pulse still generated;
  - all other behaviour identical.

## Structure
- Package `pll_seq_pkg` holds:
  - the state enum (PLL_RST, WAIT_LOCK, SETTLE, RUN);
  - the `loss_count` width constant;
  - the counter-width function (clog2 of the maximum parameter).
- One sub-module: `sync_ff`, a parameterized N-stage single-bit synchronizer with synchronous reset.

## Test plan
- Reset, then hold `pll_locked`=0 → `pll_rst` high for 16 cycles, then low for 1000000 cycles, then high again for 16 cycles (retry).
- `pll_locked` rises 100 cycles after `pll_rst` falls → `core_reset` falls exactly 2+1+1024 cycles after the rise; `ready`=1 on the same edge.
- Drop `pll_locked` for 1 cycle during SETTLE (synchronized) → return to WAIT_LOCK. After relock, a full 1024-cycle settle is required again, and `core_reset` is never released early.
- Drop `pll_locked` in RUN → `lock_lost` high for exactly 1 cycle; `core_reset`=1 and `pll_rst`=1 three cycles after the drop; `loss_count` increments by 1.
- 300 lock losses with macro defined → `loss_count` holds at 255; `reset` clears it to 0.
- `reset` asserted mid-SETTLE → next cycle: `pll_rst`=1, `core_reset`=1, `ready`=0, and the sequence restarts from PLL_RST.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL lock sequencer.
// The state enum, the loss counter width and the shared-counter width function.
package pll_seq_pkg;

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        SETTLE    = 2'd2,
        RUN       = 2'd3
    } pll_state_e;

    localparam int LOSS_CNT_W = 8;

    // Width of the one counter shared by all timed states; floor of 1 bit.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/pll_lock_sequencer_sync_ff.sv
// N-stage single-bit synchronizer with synchronous reset; output is the last stage.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// Sequences PLL reset, lock wait with retry and lock settle before releasing core reset.
// Define PLL_LOSS_COUNT_EN to add the saturating loss_count output.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 1000000,
    parameter int SETTLE_CYCLES  = 1024
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic                  pll_locked,
    output logic                  pll_rst,
    output logic                  core_reset,
    output logic                  ready,
    output logic                  lock_lost
`ifdef PLL_LOSS_COUNT_EN
    ,
    output logic [LOSS_CNT_W-1:0] loss_count
`endif
);

    localparam int CNT_W = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);

    logic       locked_s;
    pll_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic pll_rst_q, pll_rst_d;
    logic core_reset_q, core_reset_d;
    logic ready_q, ready_d;
    logic lock_lost_q, lock_lost_d;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk_sys),
        .reset (reset),
        .d     (pll_locked),
        .q     (locked_s)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        lock_lost_d = 1'b0;
        case (state_q)
            PLL_RST: begin
                if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (locked_s)                   state_d = SETTLE;
                else if (cnt_q == TIMEOUT_LAST) state_d = PLL_RST;
            end
            SETTLE: begin
                if (!locked_s)                  state_d = WAIT_LOCK;
                else if (cnt_q == SETTLE_LAST)  state_d = RUN;
            end
            RUN: begin
                // The counter is idle in RUN; hold it rather than let it wrap.
                cnt_d = cnt_q;
                if (!locked_s) begin
                    state_d     = PLL_RST;
                    lock_lost_d = 1'b1;
                end
            end
            default: state_d = PLL_RST;
        endcase
        if (state_d != state_q) cnt_d = '0;
        pll_rst_d    = (state_d == PLL_RST);
        core_reset_d = (state_d != RUN);
        ready_d      = (state_d == RUN);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= PLL_RST;
            cnt_q        <= '0;
            pll_rst_q    <= 1'b1;
            core_reset_q <= 1'b1;
            ready_q      <= 1'b0;
            lock_lost_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pll_rst_q    <= pll_rst_d;
            core_reset_q <= core_reset_d;
            ready_q      <= ready_d;
            lock_lost_q  <= lock_lost_d;
        end
    end

    assign pll_rst    = pll_rst_q;
    assign core_reset = core_reset_q;
    assign ready      = ready_q;
    assign lock_lost  = lock_lost_q;

`ifdef PLL_LOSS_COUNT_EN
    logic [LOSS_CNT_W-1:0] loss_count_q, loss_count_d;

    always_comb begin
        loss_count_d = loss_count_q;
        if (lock_lost_d && (loss_count_q != {LOSS_CNT_W{1'b1}})) begin
            loss_count_d = loss_count_q + LOSS_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            loss_count_q <= '0;
        end else begin
            loss_count_q <= loss_count_d;
        end
    end

    assign loss_count = loss_count_q;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer: expected output-change events (cycle + values)
// are queued by the driver and matched by a monitor whenever the DUT outputs change.
module tb_pll_lock_sequencer;

  localparam int SYNC_STAGES    = 2;
  localparam int PLL_RST_CYCLES = 16;
  localparam int LOCK_TIMEOUT   = 200;
  localparam int SETTLE_CYCLES  = 64;
  localparam int EW             = 44;

`ifdef PLL_LOSS_COUNT_EN
  localparam bit HAS_LOSS = 1'b1;
`else
  localparam bit HAS_LOSS = 1'b0;
`endif

  logic clk_sys = 1'b0;
  logic reset = 1'b1;
  logic pll_locked = 1'b0;
  logic pll_rst, core_reset, ready, lock_lost;
  logic [7:0] dut_loss;
  int cyc = 0;

  logic [EW-1:0] exp_q[$];
  string name_q[$];
  int chk_cnt = 0;
  int pass_cnt = 0;
  int exp_loss = 0;

`ifdef PLL_LOSS_COUNT_EN
  logic [7:0] loss_count;
  assign dut_loss = loss_count;
`else
  assign dut_loss = 8'd0;
`endif

  pll_lock_sequencer #(
    .SYNC_STAGES    (SYNC_STAGES),
    .PLL_RST_CYCLES (PLL_RST_CYCLES),
    .LOCK_TIMEOUT   (LOCK_TIMEOUT),
    .SETTLE_CYCLES  (SETTLE_CYCLES)
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .pll_locked (pll_locked),
    .pll_rst    (pll_rst),
    .core_reset (core_reset),
    .ready      (ready),
    .lock_lost  (lock_lost)
`ifdef PLL_LOSS_COUNT_EN
    ,
    .loss_count (loss_count)
`endif
  );

  // clock/reset block
  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  // driver tasks
  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk_sys);
  endtask

  task automatic push(input string nm, input int c, input logic pr, input logic cr,
                      input logic rd, input logic ll);
    logic [7:0] lv;
    lv = HAS_LOSS ? 8'(exp_loss) : 8'd0;
    exp_q.push_back({32'(c), lv, pr, cr, rd, ll});
    name_q.push_back(nm);
  endtask

  task automatic bump_loss();
    if (exp_loss < 255) exp_loss = exp_loss + 1;
  endtask

  // monitor / scoreboard
  logic [11:0] prev_sig;
  always @(negedge clk_sys) begin
    logic [EW-1:0] obs, expv;
    string nm;
    obs = {32'(cyc), dut_loss, pll_rst, core_reset, ready, lock_lost};
    if (obs[11:0] !== prev_sig) begin
      prev_sig = obs[11:0];
      chk_cnt = chk_cnt + 1;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_event: got cyc=%0d loss=%0d pr/cr/rd/ll=%b, expected no change",
                 obs[43:12], obs[11:4], obs[3:0]);
      end else begin
        expv = exp_q.pop_front();
        nm = name_q.pop_front();
        if (obs === expv) begin
          pass_cnt = pass_cnt + 1;
        end else begin
          $display("FAIL %s: got cyc=%0d loss=%0d pr/cr/rd/ll=%b, expected cyc=%0d loss=%0d pr/cr/rd/ll=%b",
                   nm, obs[43:12], obs[11:4], obs[3:0], expv[43:12], expv[11:4], expv[3:0]);
        end
      end
    end
  end

  initial begin
    int d;
    int run_c;
    int x;
    push("reset_state", 1, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_to(3);
    reset = 1'b0;
    // PLL reset window, full lock timeout, then the retry pulse
    push("pll_rst_release", 3 + PLL_RST_CYCLES, 1'b0, 1'b1, 1'b0, 1'b0);
    push("timeout_retry", 19 + LOCK_TIMEOUT, 1'b1, 1'b1, 1'b0, 1'b0);
    push("retry_release", 219 + PLL_RST_CYCLES, 1'b0, 1'b1, 1'b0, 1'b0);
    // lock 100 cycles after pll_rst falls
    wait_to(335);
    pll_locked = 1'b1;
    push("lock_to_run", 335 + SYNC_STAGES + 1 + SETTLE_CYCLES, 1'b0, 1'b0, 1'b1, 1'b0);
    // loss in RUN
    wait_to(420);
    pll_locked = 1'b0;
    bump_loss();
    push("loss_pulse", 423, 1'b1, 1'b1, 1'b0, 1'b1);
    push("loss_pulse_end", 424, 1'b1, 1'b1, 1'b0, 1'b0);
    push("loss_rst_release", 439, 1'b0, 1'b1, 1'b0, 1'b0);
    // relock, one-cycle glitch in SETTLE, full settle again
    wait_to(450);
    pll_locked = 1'b1;
    wait_to(470);
    pll_locked = 1'b0;
    wait_to(471);
    pll_locked = 1'b1;
    push("glitch_full_settle", 474 + SETTLE_CYCLES, 1'b0, 1'b0, 1'b1, 1'b0);
    // second loss, then reset in the middle of SETTLE
    wait_to(560);
    pll_locked = 1'b0;
    bump_loss();
    push("loss2_pulse", 563, 1'b1, 1'b1, 1'b0, 1'b1);
    push("loss2_pulse_end", 564, 1'b1, 1'b1, 1'b0, 1'b0);
    push("loss2_rst_release", 579, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_to(590);
    pll_locked = 1'b1;
    wait_to(600);
    reset = 1'b1;
    exp_loss = 0;
    push("reset_mid_settle", 601, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_to(603);
    reset = 1'b0;
    push("restart_release", 619, 1'b0, 1'b1, 1'b0, 1'b0);
    push("restart_run", 620 + SETTLE_CYCLES, 1'b0, 1'b0, 1'b1, 1'b0);
    // 300 losses to saturate the counter
    run_c = 684;
    for (int i = 0; i < 300; i++) begin
      d = run_c + 5;
      wait_to(d);
      pll_locked = 1'b0;
      bump_loss();
      push("sat_pulse", d + 3, 1'b1, 1'b1, 1'b0, 1'b1);
      push("sat_pulse_end", d + 4, 1'b1, 1'b1, 1'b0, 1'b0);
      push("sat_rst_release", d + 19, 1'b0, 1'b1, 1'b0, 1'b0);
      push("sat_run", d + 23 + SETTLE_CYCLES, 1'b0, 1'b0, 1'b1, 1'b0);
      wait_to(d + 20);
      pll_locked = 1'b1;
      run_c = d + 23 + SETTLE_CYCLES;
    end
    // reset clears the saturated counter
    x = run_c + 5;
    wait_to(x);
    reset = 1'b1;
    exp_loss = 0;
    push("final_reset", x + 1, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_to(x + 3);
    reset = 1'b0;
    push("final_release", x + 19, 1'b0, 1'b1, 1'b0, 1'b0);
    push("final_run", x + 20 + SETTLE_CYCLES, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_to(x + 120);
    // final report
    while (exp_q.size() != 0) begin
      logic [EW-1:0] expv;
      string nm;
      expv = exp_q.pop_front();
      nm = name_q.pop_front();
      chk_cnt = chk_cnt + 1;
      $display("FAIL %s: got no event, expected cyc=%0d loss=%0d pr/cr/rd/ll=%b",
               nm, expv[43:12], expv[11:4], expv[3:0]);
    end
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
